// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Iterative 32-bit radix-2 restoring divider (DIV / DIVU).
//               One quotient bit per cycle; 32 steps per divide.
//               A divide by zero finishes early with quotient all-ones and
//               the dividend as remainder.
//               Optional feature macro: DIV_UNIT_SIGNED_EN enables signed
//               division (sign fixup). Without it every divide is unsigned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic                  annul,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    output logic                  busy,
    output logic                  ready,
    output logic [2*DATA_W-1:0]   result
);

    // Counter value of the final shift-subtract step
    localparam logic [4:0] c_LAST_STEP = 5'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t              r_state;
    logic [4:0]          r_cnt;
    logic [DATA_W-1:0]   r_op1;      // latched dividend (raw)
    logic [DATA_W-1:0]   r_op2;      // latched divisor (raw)
    logic                r_dz;       // divisor was zero at acceptance
    logic [DATA_W-1:0]   r_rem;      // partial remainder (magnitude)
    logic [DATA_W-1:0]   r_quo;      // dividend shifts out, quotient shifts in

    logic                w_accept;
    logic [DATA_W-1:0]   w_op1_mag_in;
    logic [DATA_W-1:0]   w_dvs_mag;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_diff;

    assign w_accept = start & ~annul;

`ifdef DIV_UNIT_SIGNED_EN
    logic r_signed;
    logic w_in_neg;
    logic w_op1_neg;
    logic w_op2_neg;

    // Magnitude of the incoming dividend, loaded into the shift register
    assign w_in_neg     = signed_div & opdata1[DATA_W-1];
    assign w_op1_mag_in = w_in_neg ? -opdata1 : opdata1;

    // Sign information of the latched operands
    assign w_op1_neg = r_signed & r_op1[DATA_W-1];
    assign w_op2_neg = r_signed & r_op2[DATA_W-1];
    assign w_dvs_mag = w_op2_neg ? -r_op2 : r_op2;

    // Quotient negative when signs differ; remainder follows the dividend.
    // 0x80000000 / -1 wraps naturally: magnitude 0x80000000, no negation.
    assign w_quo_fix = (w_op1_neg ^ w_op2_neg) ? -r_quo : r_quo;
    assign w_rem_fix = w_op1_neg ? -r_rem : r_rem;

    // Signedness latch, captured together with the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signed <= 1'b0;
        end else if (!annul && r_state == S_IDLE && start) begin
            r_signed <= signed_div;
        end
    end
`else
    // Signedness request is ignored in the unsigned-only build
    logic w_unused_signed;
    assign w_unused_signed = signed_div;

    assign w_op1_mag_in = opdata1;
    assign w_dvs_mag    = r_op2;
    assign w_quo_fix    = r_quo;
    assign w_rem_fix    = r_rem;
`endif

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, w_dvs_mag};

    // Stall request: covers the accept cycle plus all working states
    assign busy = ((r_state == S_IDLE) && w_accept) ||
                  (r_state == S_ON) || (r_state == S_DIVZERO);

    // Control FSM, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_dz    <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            ready   <= 1'b0;
            result  <= '0;
        end else if (annul) begin
            // Flush: drop whatever is in flight, keep the old result
            r_state <= S_IDLE;
            ready   <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op1 <= opdata1;
                        r_op2 <= opdata2;
                        r_dz  <= (opdata2 == '0);
                        r_rem <= '0;
                        r_quo <= w_op1_mag_in;
                        r_cnt <= 5'd0;
                        r_state <= (opdata2 == '0) ? S_DIVZERO : S_ON;
                    end
                end
                S_DIVZERO: begin
                    r_state <= S_END;
                end
                S_ON: begin
                    r_rem <= w_diff[DATA_W] ? w_shift[DATA_W-1:0]
                                            : w_diff[DATA_W-1:0];
                    r_quo <= {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_STEP) begin
                        r_state <= S_END;
                    end
                end
                S_END: begin
                    result  <= r_dz ? {r_op1, {DATA_W{1'b1}}}
                                    : {w_rem_fix, w_quo_fix};
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit: directed cases, flush,
//               reset mid-divide and randomized divides against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

`ifdef DIV_UNIT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: {remainder, quotient} from plain arithmetic
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full divide: accept, scramble inputs, wait for ready with a bound
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp);
        int lat;
        int bcnt;
        @(negedge clk);
        start = 1'b1; opdata1 = a; opdata2 = b; signed_div = s;
        #1 check({tag, ".busy_req"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom_range(0, 1));
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
        end
        check({tag, ".latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        check({tag, ".busy_cycles"}, 64'(bcnt), (b == 32'd0) ? 64'd1 : 64'd32);
        check({tag, ".result"}, result, exp);
        @(posedge clk); #1;
        check({tag, ".ready_pulse"}, 64'(ready), 64'd0);
        check({tag, ".result_hold"}, result, exp);
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] ra, rb;
        logic        rs;
        int          rdy_cnt;

        rst_n = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.result", result, 64'd0);
        check("reset.ready", 64'(ready), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
                SIGNED_EN ? {32'hFFFF_FFFF, 32'hFFFF_FFFD} : {32'h1, 32'h7FFF_FFFC});
        run_div("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'h1, 32'h7FFF_FFFC});
        run_div("divzero", 32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF});
        run_div("divzero_s", 32'h8765_4321, 32'd0, 1'b1, {32'h8765_4321, 32'hFFFF_FFFF});
        run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                SIGNED_EN ? {32'h0, 32'h8000_0000} : {32'h8000_0000, 32'h0});
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
                model(32'd7, 32'hFFFF_FFFE, 1'b1));

        // Flush at iteration 10
        prev = result;
        @(negedge clk);
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul.busy", 64'(busy), 64'd0);
        check("annul.ready", 64'(ready), 64'd0);
        rdy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ready) rdy_cnt++;
        end
        check("annul.no_ready", 64'(rdy_cnt), 64'd0);
        check("annul.result_kept", result, prev);
        run_div("after_annul", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});

        // Start and flush together: nothing accepted
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
        #1 check("start_annul.busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        check("start_annul.idle", 64'(busy), 64'd0);
        rdy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ready) rdy_cnt++;
        end
        check("start_annul.no_ready", 64'(rdy_cnt), 64'd0);

        // Reset at iteration 20
        @(negedge clk);
        start = 1'b1; opdata1 = 32'h1234_5678; opdata2 = 32'h11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.result", result, 64'd0);
        check("midreset.ready", 64'(ready), 64'd0);
        check("midreset.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("after_reset", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

        // Randomized divides
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = $urandom;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_div("rand", ra, rb, rs, model(ra, rb, rs));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
